// File: rtl/uart_boot_loader_ctrl.sv
// uart_boot_loader_ctrl: parses SYNC/LEN/payload[/CSUM] frames from UART RX into imem and gates the core reset.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_boot_loader_ctrl #(
  parameter int          ADDR_W      = 8,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              ack_valid,
  output logic [7:0]        ack_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);
  localparam int CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {WAIT_SYNC, GET_LEN, GET_WORD, GET_CSUM, ACK, RUN} state_t;
  logic [7:0] csum_q, csum_d;
`else
  typedef enum logic [2:0] {WAIT_SYNC, GET_LEN, GET_WORD, ACK, RUN} state_t;
`endif
  state_t            state_q, state_d;
  logic [CW-1:0]     len_q, len_d, wcnt_q, wcnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d, gap_q, gap_d;
  logic              ack_valid_q, ack_valid_d, imem_we_q, imem_we_d;
  logic              cpu_reset_q, cpu_reset_d, load_done_q, load_done_d, load_err_q, load_err_d;
  logic [7:0]        ack_data_q, ack_data_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              in_frame, timeout, succ, err;
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    bcnt_d       = bcnt_q;
    word_d       = word_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d       = csum_q;
    in_frame     = state_q inside {GET_LEN, GET_WORD, GET_CSUM};
`else
    in_frame     = state_q inside {GET_LEN, GET_WORD};
`endif
    ack_valid_d  = ack_valid_q;
    ack_data_d   = ack_data_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    gap_d        = (rx_valid || !in_frame) ? 32'd0 : gap_q + 32'd1;
    timeout      = in_frame && !rx_valid && gap_q == 32'(TIMEOUT_CYC - 1);
    succ         = 1'b0;
    err          = 1'b0;
    case (state_q)
      WAIT_SYNC, RUN: if (rx_valid && rx_data == SYNC_BYTE) begin
        cpu_reset_d = 1'b1;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        wcnt_d      = '0;
        bcnt_d      = '0;
        state_d     = GET_LEN;
      end
      GET_LEN: if (rx_valid) begin
        if (rx_data == 8'd0 || CW'(rx_data) > CW'(2 ** ADDR_W)) err = 1'b1;
        else begin
          len_d   = CW'(rx_data);
`ifdef BOOT_CHECKSUM_EN
          csum_d  = rx_data;
`endif
          state_d = GET_WORD;
        end
      end
      GET_WORD: begin
        if (rx_valid) begin
          word_d = {rx_data, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wcnt_q[ADDR_W-1:0];
            imem_wdata_d = {rx_data, word_q[31:8]};
            wcnt_d       = wcnt_q + 1'b1;
          end
        end
        // The frame is finished only in the write cycle of the last word, so imem_we stays inside GET_WORD.
        if (imem_we_q && wcnt_q == len_q) begin
`ifdef BOOT_CHECKSUM_EN
          if (rx_valid) begin
            succ = rx_data == csum_q;
            err  = rx_data != csum_q;
          end else state_d = GET_CSUM;
`else
          succ = 1'b1;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      GET_CSUM: if (rx_valid) begin
        succ = rx_data == csum_q;
        err  = rx_data != csum_q;
      end
`endif
      ACK: if (tx_ready) begin
        ack_valid_d = 1'b0;
        cpu_reset_d = !load_done_q;
        state_d     = load_done_q ? RUN : WAIT_SYNC;
      end
      default: state_d = WAIT_SYNC;
    endcase
    if (succ) begin
      load_done_d = 1'b1;
      ack_data_d  = 8'h06;
      ack_valid_d = 1'b1;
      state_d     = ACK;
    end else if (err || timeout) begin
      load_err_d  = 1'b1;
      ack_data_d  = 8'h15;
      ack_valid_d = 1'b1;
      state_d     = ACK;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_SYNC;
      len_q        <= '0;
      wcnt_q       <= '0;
      bcnt_q       <= '0;
      word_q       <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
      gap_q        <= '0;
      ack_valid_q  <= 1'b0;
      ack_data_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      gap_q        <= gap_d;
      ack_valid_q  <= ack_valid_d;
      ack_data_q   <= ack_data_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end
  assign ack_valid  = ack_valid_q;
  assign ack_data   = ack_data_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// tb_uart_boot_loader_ctrl: directed frame tests for the UART boot loader (honours BOOT_CHECKSUM_EN).
module tb_uart_boot_loader_ctrl;
  localparam int TO = 200;
  logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic ack_valid, imem_we, cpu_reset, load_done, load_err;
  logic [7:0] ack_data, imem_addr;
  logic [31:0] imem_wdata;
  logic s_ack_valid, s_imem_we, s_cpu_reset, s_load_done, s_load_err;
  logic [7:0] s_ack_data;
  logic [0:0] s_imem_addr;
  logic [31:0] s_imem_wdata;
  int vectors = 0, miscompares = 0;
  logic [7:0] wr_addr[$];
  logic [31:0] wr_data[$];
  uart_boot_loader_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .ack_valid(ack_valid), .ack_data(ack_data), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err));
  uart_boot_loader_ctrl #(.ADDR_W(1), .TIMEOUT_CYC(TO)) dut_small (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .ack_valid(s_ack_valid), .ack_data(s_ack_data), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_reset(s_cpu_reset), .load_done(s_load_done), .load_err(s_load_err));
  always #5 clk = ~clk;
  always @(negedge clk) if (imem_we) begin
    wr_addr.push_back(imem_addr);
    wr_data.push_back(imem_wdata);
  end
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic send_seq(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send_byte(q[i], gap);
  endtask
  task automatic wait_ack(input int limit, output bit found, output int n);
    found = 0;
    n = 0;
    while (!found && n < limit) begin
      if (ack_valid === 1'b1) found = 1;
      else begin @(negedge clk); n++; end
    end
  endtask
  task automatic release_ack();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask
  task automatic test_reset();
    int bad;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cpu_reset, ack_valid, imem_we, load_done, load_err, ack_data, imem_addr, imem_wdata} !== {1'b1, 4'b0, 8'h00, 8'h00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_values: got cr=%b av=%b we=%b ld=%b le=%b ad=%h ia=%h wd=%h want cr=1 rest 0", cpu_reset, ack_valid, imem_we, load_done, load_err, ack_data, imem_addr, imem_wdata);
    end
    reset = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cpu_reset !== 1'b1 || imem_we !== 1'b0 || ack_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL reset_idle: %0d bad cycles, want 0", bad); end
  endtask
  task automatic test_single_word();
    logic [7:0] q[$] = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
    bit found;
    int n;
`ifdef BOOT_CHECKSUM_EN
    q.push_back(8'h12);
`endif
    wr_addr.delete(); wr_data.delete();
    send_seq(q, 2);
    wait_ack(50, found, n);
    vectors++;
    if (!found || ack_data !== 8'h06) begin miscompares++; $display("FAIL single_ack: found=%0d data=%h want 1/06", found, ack_data); end
    vectors++;
    if ({load_done, load_err, cpu_reset} !== 3'b101) begin miscompares++; $display("FAIL single_flags: ld/le/cr=%b%b%b want 101", load_done, load_err, cpu_reset); end
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00000013) begin
      miscompares++;
      $display("FAIL single_write: count=%0d addr=%h data=%h want 1/00/00000013", wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 8'hxx, wr_data.size() > 0 ? wr_data[0] : 32'hx);
    end
    send_byte(8'hA5, 3);
    vectors++;
    if (ack_valid !== 1'b1 || ack_data !== 8'h06 || cpu_reset !== 1'b1) begin miscompares++; $display("FAIL ack_hold: av=%b ad=%h cr=%b want 1/06/1", ack_valid, ack_data, cpu_reset); end
    release_ack();
    vectors++;
    if (ack_valid !== 1'b0 || cpu_reset !== 1'b0 || load_done !== 1'b1) begin miscompares++; $display("FAIL ack_release: av=%b cr=%b ld=%b want 0/0/1", ack_valid, cpu_reset, load_done); end
    repeat (5) @(negedge clk);
    vectors++;
    if (cpu_reset !== 1'b0) begin miscompares++; $display("FAIL ack_drops_sync: cr=%b want 0", cpu_reset); end
  endtask
  task automatic test_two_words(input int gap);
    logic [7:0] q[$] = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    bit found;
    int n;
`ifdef BOOT_CHECKSUM_EN
    q.push_back(8'h0A);
`endif
    wr_addr.delete(); wr_data.delete();
    send_byte(8'hA5, 0);
    vectors++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin miscompares++; $display("FAIL sync_from_run gap%0d: cr=%b ld=%b want 1/0", gap, cpu_reset, load_done); end
    send_seq(q, gap);
    wait_ack(50, found, n);
    vectors++;
    if (!found || ack_data !== 8'h06) begin miscompares++; $display("FAIL two_ack gap%0d: found=%0d data=%h want 1/06", gap, found, ack_data); end
    vectors++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h04030201 || wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h08070605) begin
      miscompares++;
      $display("FAIL two_writes gap%0d: count=%0d want 2 (00:04030201, 01:08070605)", gap, wr_addr.size());
      foreach (wr_addr[i]) $display("  write %0d: addr=%h data=%h", i, wr_addr[i], wr_data[i]);
    end
    release_ack();
    vectors++;
    if (cpu_reset !== 1'b0 || ack_valid !== 1'b0) begin miscompares++; $display("FAIL two_run gap%0d: cr=%b av=%b want 0/0", gap, cpu_reset, ack_valid); end
  endtask
  task automatic test_zero_len();
    logic [7:0] q[$] = '{8'hA5, 8'h00};
    bit found;
    int n;
    wr_addr.delete(); wr_data.delete();
    send_seq(q, 2);
    wait_ack(50, found, n);
    vectors++;
    if (!found || ack_data !== 8'h15 || load_err !== 1'b1 || load_done !== 1'b0) begin miscompares++; $display("FAIL zero_len: found=%0d data=%h le=%b ld=%b want 1/15/1/0", found, ack_data, load_err, load_done); end
    release_ack();
    vectors++;
    if (wr_addr.size() != 0 || cpu_reset !== 1'b1 || ack_valid !== 1'b0) begin miscompares++; $display("FAIL zero_len_after: writes=%0d cr=%b av=%b want 0/1/0", wr_addr.size(), cpu_reset, ack_valid); end
  endtask
  task automatic test_timeout();
    logic [7:0] a[$] = '{8'hA5, 8'h01, 8'h13};
    logic [7:0] b[$] = '{8'h00, 8'h00, 8'h00};
    bit found;
    int n;
`ifdef BOOT_CHECKSUM_EN
    b.push_back(8'h12);
`endif
    wr_addr.delete(); wr_data.delete();
    send_seq(a, 1);
    repeat (TO - 10) @(negedge clk);
    send_seq(b, 1);
    wait_ack(50, found, n);
    vectors++;
    if (!found || ack_data !== 8'h06 || wr_addr.size() != 1) begin miscompares++; $display("FAIL near_timeout: found=%0d data=%h writes=%0d want 1/06/1", found, ack_data, wr_addr.size()); end
    release_ack();
    wr_addr.delete(); wr_data.delete();
    send_seq(a, 0);
    wait_ack(TO + 50, found, n);
    vectors++;
    if (!found || ack_data !== 8'h15 || load_err !== 1'b1) begin miscompares++; $display("FAIL timeout_nak: found=%0d data=%h le=%b want 1/15/1", found, ack_data, load_err); end
    vectors++;
    if (n < TO - 2 || n > TO + 2) begin miscompares++; $display("FAIL timeout_latency: %0d cycles want about %0d", n, TO); end
    release_ack();
    vectors++;
    if (wr_addr.size() != 0 || cpu_reset !== 1'b1) begin miscompares++; $display("FAIL timeout_after: writes=%0d cr=%b want 0/1", wr_addr.size(), cpu_reset); end
  endtask
`ifdef BOOT_CHECKSUM_EN
  task automatic test_bad_csum();
    logic [7:0] q[$] = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};
    bit found;
    int n;
    wr_addr.delete(); wr_data.delete();
    send_seq(q, 2);
    wait_ack(50, found, n);
    vectors++;
    if (!found || ack_data !== 8'h15 || wr_addr.size() != 1) begin miscompares++; $display("FAIL bad_csum: found=%0d data=%h writes=%0d want 1/15/1", found, ack_data, wr_addr.size()); end
    release_ack();
    vectors++;
    if (cpu_reset !== 1'b1 || load_err !== 1'b1) begin miscompares++; $display("FAIL bad_csum_after: cr=%b le=%b want 1/1", cpu_reset, load_err); end
  endtask
`endif
  task automatic test_reset_mid_frame();
    logic [7:0] a[$] = '{8'hA5, 8'h02, 8'h01, 8'h02};
    logic [7:0] b[$] = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bit found;
    int n;
`ifdef BOOT_CHECKSUM_EN
    b.push_back(8'h23);
`endif
    send_seq(a, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({cpu_reset, ack_valid, load_done, load_err} !== 4'b1000) begin miscompares++; $display("FAIL mid_reset: cr/av/ld/le=%b%b%b%b want 1000", cpu_reset, ack_valid, load_done, load_err); end
    wr_addr.delete(); wr_data.delete();
    send_seq(b, 1);
    wait_ack(50, found, n);
    vectors++;
    if (!found || ack_data !== 8'h06 || wr_addr.size() != 1 || wr_data[0] !== 32'hDEADBEEF || wr_addr[0] !== 8'h00) begin
      miscompares++;
      $display("FAIL after_mid_reset: found=%0d data=%h writes=%0d want 1/06/1 at 00:deadbeef", found, ack_data, wr_addr.size());
    end
    release_ack();
  endtask
  task automatic test_len_limit();
    logic [7:0] ok[$] = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] big[$] = '{8'hA5, 8'h03};
    int n;
`ifdef BOOT_CHECKSUM_EN
    ok.push_back(8'h0A);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_seq(big, 2);
    n = 0;
    while (s_ack_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (s_ack_valid !== 1'b1 || s_ack_data !== 8'h15 || s_load_err !== 1'b1) begin miscompares++; $display("FAIL len_over_limit: av=%b data=%h le=%b want 1/15/1", s_ack_valid, s_ack_data, s_load_err); end
    release_ack();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_seq(ok, 1);
    n = 0;
    while (s_ack_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (s_ack_valid !== 1'b1 || s_ack_data !== 8'h06 || s_load_done !== 1'b1) begin miscompares++; $display("FAIL len_at_limit: av=%b data=%h ld=%b want 1/06/1", s_ack_valid, s_ack_data, s_load_done); end
    release_ack();
    vectors++;
    if (s_cpu_reset !== 1'b0) begin miscompares++; $display("FAIL len_at_limit_run: cr=%b want 0", s_cpu_reset); end
  endtask
  initial begin
    test_reset();
    test_single_word();
    test_two_words(1);
    test_two_words(0);
    test_zero_len();
    test_timeout();
`ifdef BOOT_CHECKSUM_EN
    test_bad_csum();
`endif
    test_reset_mid_frame();
    test_len_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
